// File: rtl/obf_key_ctrl.sv
// Serial key loader for a camouflaged netlist: shifts in KEY_W key bits LSB first plus one
// even-parity bit, then drives the checked key onto the cell select pins and can lock it.
module obf_key_ctrl #(
  parameter int NUM_CELLS = 5,
  parameter int KEY_W     = 2 * NUM_CELLS,
  localparam int CNT_W    = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_in_valid,
  input  logic             key_in_bit,
  output logic             key_in_ready,
  input  logic             lock_req,
  output logic [KEY_W-1:0] d_out,
  output logic             cfg_valid,
  output logic             locked,
  output logic             busy,
  output logic             err,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_CHECK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [KEY_W-1:0]   shadow, shadow_next;
  logic               par, par_next;
  logic [KEY_W-1:0]   d_next;
  logic               cfg_next;
  logic               err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      shadow    <= '0;
      par       <= 1'b0;
      d_out     <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shadow    <= shadow_next;
      par       <= par_next;
      d_out     <= d_next;
      cfg_valid <= cfg_next;
      err       <= err_next;
    end
  end

  // Handshake: a bit transfers on each rising edge where key_in_valid and key_in_ready are
  // both high; ready is a pure decode of the registered state, so it never depends on valid.
  assign key_in_ready = (state == S_SHIFT);
  assign busy         = (state == S_SHIFT) || (state == S_CHECK);
  assign locked       = (state == S_LOCKED);
  assign dbg_state    = state;
  assign dbg_cnt      = cnt;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow;
    par_next    = par;
    d_next      = d_out;
    cfg_next    = cfg_valid;
    err_next    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) begin
          shadow_next = '0;
          cnt_next    = '0;
          state_next  = S_SHIFT;
        end else if (lock_req && cfg_valid) begin
          state_next  = S_LOCKED;
        end
      end
      S_SHIFT: begin
        // A restart discards whatever bit is offered in the same cycle.
        if (load_start) begin
          shadow_next = '0;
          cnt_next    = '0;
        end else if (key_in_valid) begin
          if (cnt == CNT_W'(KEY_W)) begin
            par_next   = key_in_bit;
            state_next = S_CHECK;
          end else begin
            for (int i = 0; i < KEY_W; i++) begin
              if (cnt == CNT_W'(i)) shadow_next[i] = key_in_bit;
            end
            cnt_next = cnt + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if ((^shadow ^ par) == 1'b0) begin
          d_next   = shadow;
          cfg_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
        state_next = S_IDLE;
      end
      S_LOCKED: begin
        if (load_start) err_next = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
